cic_rate_ctrl: RTL and testbench
================================

Name: cic_rate_ctrl

Overview:
Run-time decimation-rate controller that sits between the configuration source and a variable-rate CIC decimator. It accepts rate-change requests, range-checks them, flushes the CIC, loads the new rate and discards the transient output samples. It then re-opens the output stream. Downstream logic sees only clean samples at a known rate.

Parameters:
DATA_W, 18, CIC output sample width (passthrough)
RATE_W, 18, rate word width; matches CIC input width
R_MIN, 2, smallest legal decimation ratio
R_MAX, 10, largest legal decimation ratio; also the rate loaded after reset
FLUSH_CYCLES, 4, clocks for which cic_reset_n is held low per reconfiguration
SETTLE_SAMPLES, 7, CIC output samples discarded after each load; set to CIC_N

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axis_cfg_tdata  in  RATE_W  requested decimation ratio (unsigned)
s_axis_cfg_tvalid  in  1  request valid
s_axis_cfg_tready  out  1  request accepted when tvalid&tready
cic_reset_n  out  1  active-low flush to the CIC
m_axis_rate_tdata  out  RATE_W  rate word to the CIC rate port
m_axis_rate_tvalid  out  1  one-cycle rate load strobe
s_axis_cic_tdata  in  DATA_W  CIC output sample
s_axis_cic_tvalid  in  1  CIC output strobe (no backpressure)
m_axis_out_tdata  out  DATA_W  gated sample
m_axis_out_tvalid  out  1  gated strobe
cur_rate  out  RATE_W  rate currently in effect
busy  out  1  high in any state other than RUN
err_rate  out  1  one-cycle pulse on an out-of-range request

Behaviour:
- Reset values:
  - state=LOAD, cur_rate=R_MAX, cic_reset_n=0
  - m_axis_rate_tvalid=0, m_axis_out_tvalid=0, m_axis_out_tdata=0
  - busy=1, err_rate=0, s_axis_cfg_tready=0
- All outputs are registered. Reset asserted mid-operation aborts any sequence and discards any pending request.
- States: RUN, FLUSH, LOAD, SETTLE. Encoding comes from the package.
- RUN:
  - s_axis_cfg_tready=1.
  - On handshake with R_MIN<=tdata<=R_MAX: latch tdata into pending_rate, go to FLUSH, clear the flush counter.
  - On handshake with an out-of-range value: pulse err_rate next cycle, stay in RUN, cur_rate unchanged.
- FLUSH:
  - cic_reset_n=0 for exactly FLUSH_CYCLES clocks, then go to LOAD.
- LOAD (one cycle):
  - m_axis_rate_tvalid=1, m_axis_rate_tdata=pending_rate, cic_reset_n=1.
  - cur_rate updates to pending_rate.
  - Next state is SETTLE with the settle counter cleared.
  - After reset, pending_rate=R_MAX. cic_reset_n rises on the first clock after reset deasserts.
- SETTLE:
  - Count s_axis_cic_tvalid pulses.
  - After SETTLE_SAMPLES pulses are counted, go to RUN. The last discarded sample is not forwarded.
- s_axis_cfg_tready=0 in FLUSH, LOAD and SETTLE. Requests are held off, never dropped.
- Datapath:
  - m_axis_out_tdata/tvalid register s_axis_cic_tdata/tvalid with 1-clock latency.
  - tvalid is forwarded only when state==RUN in the sampling cycle.
  - tdata updates only on a forwarded sample and holds otherwise.
- Simultaneous events: a cfg handshake and a CIC sample in the same RUN cycle forwards the sample; FLUSH begins next cycle.
- Sequence timing: a handshake accepted at cycle t gives
  - cic_reset_n low at t+1..t+FLUSH_CYCLES
  - LOAD at t+FLUSH_CYCLES+1
  - SETTLE from t+FLUSH_CYCLES+2
- Re-requesting the value already in cur_rate still runs the full sequence.
- Counter widths: clog2(FLUSH_CYCLES+1) for the flush counter and clog2(SETTLE_SAMPLES+1) for the settle counter. No wrap is possible because the counters stop at their terminal value.
- Comparison is unsigned over RATE_W. tdata=0 is out of range.

Decomposition:
- Package cic_ctrl_pkg holds:
  - typedef enum logic [1:0] {RUN, FLUSH, LOAD, SETTLE} cic_ctrl_state_t
  - a clog2 constant function, shared with other CIC blocks
- Single module; no sub-module is warranted.

Test Plan:
- Power-up: deassert reset; expect LOAD with m_axis_rate_tdata=10 strobed once, 7 CIC samples swallowed, busy falls, 8th sample appears on m_axis_out 1 clock after input.
- Legal change: in RUN send tdata=4; expect tready low next cycle, cic_reset_n low exactly 4 clocks, one rate strobe with 4, cur_rate=4, next 7 samples discarded, then passthrough resumes.
- Illegal requests: send tdata=1, then 11, then 0; expect each accepted in 1 cycle with an err_rate pulse, no cic_reset_n activity, cur_rate unchanged, samples uninterrupted.
- Back-pressure: hold tvalid with tdata=6 throughout a SETTLE; expect tready=0 until RUN, then accepted exactly once and a second full sequence to rate 6.
- Collision: cfg handshake (tdata=5) in the same cycle as s_axis_cic_tvalid with tdata=0x1234; expect 0x1234 forwarded next cycle, then FLUSH.
- Mid-sequence reset: assert reset during the 2nd FLUSH cycle of a change to 3; expect all outputs at reset values, cur_rate=10, and a post-reset sequence loading 10, not 3.

Source files
------------

// File: rtl/cic_rate_ctrl_pkg.sv
// rtl/cic_rate_ctrl_pkg.sv - shared types and helpers for the CIC control blocks
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } cic_ctrl_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - run-time decimation-rate controller for a variable-rate CIC
module cic_rate_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int DATA_W         = 18,
  parameter int RATE_W         = 18,
  parameter int R_MIN          = 2,
  parameter int R_MAX          = 10,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RATE_W-1:0] s_axis_cfg_tdata,
  input  logic              s_axis_cfg_tvalid,
  output logic              s_axis_cfg_tready,
  output logic              cic_reset_n,
  output logic [RATE_W-1:0] m_axis_rate_tdata,
  output logic              m_axis_rate_tvalid,
  input  logic [DATA_W-1:0] s_axis_cic_tdata,
  input  logic              s_axis_cic_tvalid,
  output logic [DATA_W-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic [RATE_W-1:0] cur_rate,
  output logic              busy,
  output logic              err_rate
);

  localparam int FLUSH_W  = clog2(FLUSH_CYCLES + 1);
  localparam int SETTLE_W = clog2(SETTLE_SAMPLES + 1);

  cic_ctrl_state_t     state;
  cic_ctrl_state_t     state_nxt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [RATE_W-1:0]   pending_rate;
  logic                cfg_fire;
  logic                rate_ok;
  logic                fwd;

  assign cfg_fire = s_axis_cfg_tvalid & s_axis_cfg_tready;
  assign rate_ok  = (s_axis_cfg_tdata >= RATE_W'(R_MIN)) && (s_axis_cfg_tdata <= RATE_W'(R_MAX));
  assign fwd      = s_axis_cic_tvalid && (state == RUN);

  // LOAD leaves only once its strobe has been presented, so the LOAD entered
  // from reset lasts an extra cycle while the registered outputs catch up.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:    if (cfg_fire && rate_ok) state_nxt = FLUSH;
      FLUSH:  if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) state_nxt = LOAD;
      LOAD:   if (m_axis_rate_tvalid) state_nxt = SETTLE;
      SETTLE: if (s_axis_cic_tvalid && settle_cnt == SETTLE_W'(SETTLE_SAMPLES - 1)) state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= LOAD;
      flush_cnt          <= '0;
      settle_cnt         <= '0;
      pending_rate       <= RATE_W'(R_MAX);
      cur_rate           <= RATE_W'(R_MAX);
      cic_reset_n        <= 1'b0;
      m_axis_rate_tvalid <= 1'b0;
      m_axis_rate_tdata  <= RATE_W'(R_MAX);
      m_axis_out_tvalid  <= 1'b0;
      m_axis_out_tdata   <= '0;
      busy               <= 1'b1;
      err_rate           <= 1'b0;
      s_axis_cfg_tready  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state != FLUSH)
        flush_cnt <= '0;
      else if (flush_cnt != FLUSH_W'(FLUSH_CYCLES))
        flush_cnt <= flush_cnt + FLUSH_W'(1);

      if (state != SETTLE)
        settle_cnt <= '0;
      else if (s_axis_cic_tvalid && settle_cnt != SETTLE_W'(SETTLE_SAMPLES))
        settle_cnt <= settle_cnt + SETTLE_W'(1);

      if (cfg_fire && rate_ok) pending_rate <= s_axis_cfg_tdata;
      err_rate <= cfg_fire && !rate_ok;

      // Control outputs follow the state being entered so they line up with it.
      s_axis_cfg_tready  <= (state_nxt == RUN);
      busy               <= (state_nxt != RUN);
      cic_reset_n        <= (state_nxt != FLUSH);
      m_axis_rate_tvalid <= (state_nxt == LOAD);
      if (state_nxt == LOAD) begin
        m_axis_rate_tdata <= pending_rate;
        cur_rate          <= pending_rate;
      end

      m_axis_out_tvalid <= fwd;
      if (fwd) m_axis_out_tdata <= s_axis_cic_tdata;
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - randomized self-checking bench for cic_rate_ctrl
module tb_cic_rate_ctrl;

  localparam int DATA_W = 18;
  localparam int RATE_W = 18;
  localparam int R_MIN  = 2;
  localparam int R_MAX  = 10;
  localparam int F      = 4;
  localparam int S      = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [RATE_W-1:0] s_axis_cfg_tdata = '0;
  logic              s_axis_cfg_tvalid = 1'b0;
  logic              s_axis_cfg_tready;
  logic              cic_reset_n;
  logic [RATE_W-1:0] m_axis_rate_tdata;
  logic              m_axis_rate_tvalid;
  logic [DATA_W-1:0] s_axis_cic_tdata = '0;
  logic              s_axis_cic_tvalid = 1'b0;
  logic [DATA_W-1:0] m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic [RATE_W-1:0] cur_rate;
  logic              busy;
  logic              err_rate;

  always #5 clk = ~clk;

  cic_rate_ctrl #(
    .DATA_W(DATA_W), .RATE_W(RATE_W), .R_MIN(R_MIN), .R_MAX(R_MAX),
    .FLUSH_CYCLES(F), .SETTLE_SAMPLES(S)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_cfg_tdata(s_axis_cfg_tdata), .s_axis_cfg_tvalid(s_axis_cfg_tvalid),
    .s_axis_cfg_tready(s_axis_cfg_tready), .cic_reset_n(cic_reset_n),
    .m_axis_rate_tdata(m_axis_rate_tdata), .m_axis_rate_tvalid(m_axis_rate_tvalid),
    .s_axis_cic_tdata(s_axis_cic_tdata), .s_axis_cic_tvalid(s_axis_cic_tvalid),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
    .cur_rate(cur_rate), .busy(busy), .err_rate(err_rate)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of the reconfiguration as cycle stamps.
  // cyc counts clock edges since reset released; cycle 0 is the reset state.
  int                cyc;
  int                load_at;
  int                flush_from;
  int                flush_to;
  int                discards_left;
  bit                stream_open;
  bit                was_open;
  bit                discarding;
  logic [RATE_W-1:0] pending;
  logic              exp_tready, exp_cic_reset_n, exp_rate_tvalid, exp_out_tvalid, exp_busy, exp_err;
  logic [RATE_W-1:0] exp_rate_tdata, exp_cur_rate;
  logic [DATA_W-1:0] exp_out_tdata;

  always @(posedge clk) begin
    if (reset) begin
      cyc = 0; load_at = 1; flush_from = 1; flush_to = 0;
      discards_left = S; stream_open = 0; pending = RATE_W'(R_MAX);
      exp_tready = 0; exp_cic_reset_n = 0; exp_rate_tvalid = 0; exp_out_tvalid = 0;
      exp_busy = 1; exp_err = 0; exp_rate_tdata = RATE_W'(R_MAX);
      exp_cur_rate = RATE_W'(R_MAX); exp_out_tdata = '0;
    end else begin
      was_open   = stream_open;
      discarding = !stream_open && (cyc >= load_at + 1) && (discards_left > 0);
      cyc++;
      exp_err = 0;
      exp_out_tvalid = was_open && s_axis_cic_tvalid;
      if (exp_out_tvalid) exp_out_tdata = s_axis_cic_tdata;
      if (was_open && s_axis_cfg_tvalid) begin
        if (s_axis_cfg_tdata >= R_MIN && s_axis_cfg_tdata <= R_MAX) begin
          pending = s_axis_cfg_tdata;
          flush_from = cyc; flush_to = cyc + F - 1; load_at = cyc + F;
          discards_left = S; stream_open = 0;
        end else begin
          exp_err = 1;
        end
      end
      if (discarding && s_axis_cic_tvalid) begin
        discards_left--;
        if (discards_left == 0) stream_open = 1;
      end
      exp_cic_reset_n = !(cyc >= flush_from && cyc <= flush_to);
      exp_rate_tvalid = (cyc == load_at);
      if (exp_rate_tvalid) begin
        exp_rate_tdata = pending;
        exp_cur_rate   = pending;
      end
      exp_tready = stream_open;
      exp_busy   = !stream_open;
    end
  end

  int                strobe_cnt = 0;
  int                low_cnt = 0;
  int                err_cnt = 0;
  logic [RATE_W-1:0] last_strobe = '0;

  always @(posedge clk) begin
    #1;
    chk("tready", 32'(s_axis_cfg_tready), 32'(exp_tready));
    chk("cic_reset_n", 32'(cic_reset_n), 32'(exp_cic_reset_n));
    chk("rate_tvalid", 32'(m_axis_rate_tvalid), 32'(exp_rate_tvalid));
    chk("rate_tdata", 32'(m_axis_rate_tdata), 32'(exp_rate_tdata));
    chk("out_tvalid", 32'(m_axis_out_tvalid), 32'(exp_out_tvalid));
    chk("out_tdata", 32'(m_axis_out_tdata), 32'(exp_out_tdata));
    chk("cur_rate", 32'(cur_rate), 32'(exp_cur_rate));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("err_rate", 32'(err_rate), 32'(exp_err));
    if (m_axis_rate_tvalid) begin
      strobe_cnt++;
      last_strobe = m_axis_rate_tdata;
    end
    if (!cic_reset_n && !reset) low_cnt++;
    if (err_rate) err_cnt++;
  end

  bit cic_auto = 1'b1;
  always @(negedge clk) begin
    if (cic_auto) begin
      s_axis_cic_tvalid = ($urandom_range(0, 2) != 0);
      s_axis_cic_tdata  = DATA_W'($urandom);
    end
  end

  task automatic send_cfg(input logic [RATE_W-1:0] v);
    logic rdy;
    int   n;
    @(negedge clk);
    s_axis_cfg_tdata  = v;
    s_axis_cfg_tvalid = 1'b1;
    rdy = s_axis_cfg_tready;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy) break;
      rdy = s_axis_cfg_tready;
      n++;
      if (n > 300) begin
        compared++; mismatched++;
        $display("FAIL cfg_accept: no handshake within 300 cycles, required one");
        break;
      end
    end
    s_axis_cfg_tvalid = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        compared++; mismatched++;
        $display("FAIL wait_run: busy still %b after 300 cycles, required 0", busy);
        break;
      end
    end
  endtask

  int s0, low0, e0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cur_rate", 32'(cur_rate), 32'd10);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cic_reset_n", 32'(cic_reset_n), 32'd0);
    chk("rst_tready", 32'(s_axis_cfg_tready), 32'd0);
    reset = 1'b0;
    wait_run();
    chk("pwr_strobes", 32'(strobe_cnt), 32'd1);
    chk("pwr_rate", 32'(last_strobe), 32'd10);
    chk("pwr_no_flush", 32'(low_cnt), 32'd0);

    s0 = strobe_cnt; low0 = low_cnt;
    send_cfg(4);
    wait_run();
    chk("chg4_flush_len", 32'(low_cnt - low0), 32'd4);
    chk("chg4_strobes", 32'(strobe_cnt - s0), 32'd1);
    chk("chg4_rate", 32'(last_strobe), 32'd4);
    chk("chg4_cur", 32'(cur_rate), 32'd4);

    e0 = err_cnt; low0 = low_cnt;
    send_cfg(1);
    send_cfg(11);
    send_cfg(0);
    repeat (2) @(negedge clk);
    chk("bad_errs", 32'(err_cnt - e0), 32'd3);
    chk("bad_no_flush", 32'(low_cnt - low0), 32'd0);
    chk("bad_cur", 32'(cur_rate), 32'd4);

    s0 = strobe_cnt;
    send_cfg(8);
    send_cfg(6);
    wait_run();
    chk("bp_strobes", 32'(strobe_cnt - s0), 32'd2);
    chk("bp_cur", 32'(cur_rate), 32'd6);

    @(negedge clk);
    cic_auto = 1'b0;
    s_axis_cfg_tdata = 5; s_axis_cfg_tvalid = 1'b1;
    s_axis_cic_tdata = 18'h1234; s_axis_cic_tvalid = 1'b1;
    @(posedge clk); #1;
    chk("col_tvalid", 32'(m_axis_out_tvalid), 32'd1);
    chk("col_tdata", 32'(m_axis_out_tdata), 32'h1234);
    chk("col_flush", 32'(cic_reset_n), 32'd0);
    @(negedge clk);
    s_axis_cfg_tvalid = 1'b0; s_axis_cic_tvalid = 1'b0;
    cic_auto = 1'b1;
    wait_run();
    chk("col_cur", 32'(cur_rate), 32'd5);

    send_cfg(3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_cur", 32'(cur_rate), 32'd10);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_cic_reset_n", 32'(cic_reset_n), 32'd0);
    chk("mid_rate_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
    chk("mid_out_tvalid", 32'(m_axis_out_tvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    wait_run();
    chk("mid_strobes", 32'(strobe_cnt - s0), 32'd1);
    chk("mid_rate", 32'(last_strobe), 32'd10);
    chk("mid_cur_after", 32'(cur_rate), 32'd10);

    repeat (40) begin
      send_cfg(RATE_W'($urandom_range(0, 12)));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
